// File: rtl/mdu_unit.sv
// rtl/mdu_unit.sv - multi-cycle multiply/divide unit with HI/LO registers (option: MDU_DIV0_KEEP_EN)
module mdu_unit #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        Start,
   input  logic [3:0]  Multop,
   input  logic [31:0] A,
   input  logic [31:0] B,
   input  logic        Req,
   output logic        Busy,
   output logic [31:0] HI,
   output logic [31:0] LO,
   output logic [31:0] MDUout
);

   typedef enum logic {IDLE, RUN} state_t;

   state_t      state_q, state_d;
   logic [31:0] cnt_q, cnt_d;
   logic [31:0] hi_q, hi_d, lo_q, lo_d;
   logic [31:0] thi_q, thi_d, tlo_q, tlo_d;

   logic        is_mul, is_div, b_nz;
   logic [63:0] prod_s, prod_u;
   logic [31:0] a_mag, b_mag, b_sdiv, b_udiv;
   logic [31:0] mag_q, mag_r, sq, sr, uq, ur;
   logic [31:0] div0_hi, div0_lo;

   assign is_mul = (Multop == 4'd1) || (Multop == 4'd7);
   assign is_div = (Multop == 4'd2) || (Multop == 4'd8);
   assign b_nz   = (B != 32'd0);

   // Low 64 bits of a product of sign-extended operands equal the signed product
   assign prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
   assign prod_u = {32'd0, A} * {32'd0, B};

   // Signed divide on magnitudes; -2^31 / -1 falls out as 0x80000000 rem 0
   assign a_mag  = A[31] ? (32'd0 - A) : A;
   assign b_mag  = B[31] ? (32'd0 - B) : B;
   assign b_sdiv = b_nz ? b_mag : 32'd1;
   assign b_udiv = b_nz ? B : 32'd1;
   assign mag_q  = a_mag / b_sdiv;
   assign mag_r  = a_mag % b_sdiv;
   assign sq     = (A[31] ^ B[31]) ? (32'd0 - mag_q) : mag_q;
   assign sr     = A[31] ? (32'd0 - mag_r) : mag_r;
   assign uq     = A / b_udiv;
   assign ur     = A % b_udiv;

`ifdef MDU_DIV0_KEEP_EN
   assign div0_hi = hi_q;
   assign div0_lo = lo_q;
`else
   assign div0_hi = A;
   assign div0_lo = 32'hFFFF_FFFF;
`endif

   assign Busy   = (state_q == RUN);
   assign HI     = hi_q;
   assign LO     = lo_q;
   assign MDUout = (Multop == 4'd5) ? hi_q : ((Multop == 4'd6) ? lo_q : 32'd0);

   // Next-state: accept commands in IDLE, count down and commit in RUN
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      thi_d   = thi_q;
      tlo_d   = tlo_q;
      if (state_q == IDLE) begin
         if (!Req) begin
            if (Start && (is_mul || is_div)) begin
               state_d = RUN;
               cnt_d   = is_div ? 32'(DIV_CYCLES) : 32'(MULT_CYCLES);
               case (Multop)
                  4'd1:    {thi_d, tlo_d} = prod_s;
                  4'd7:    {thi_d, tlo_d} = prod_u;
                  4'd2:    {thi_d, tlo_d} = b_nz ? {sr, sq} : {div0_hi, div0_lo};
                  default: {thi_d, tlo_d} = b_nz ? {ur, uq} : {div0_hi, div0_lo};
               endcase
            end else if (Multop == 4'd3) begin
               hi_d = A;
            end else if (Multop == 4'd4) begin
               lo_d = A;
            end
         end
      end else begin
         if (cnt_q == 32'd1) begin
            hi_d    = thi_q;
            lo_d    = tlo_q;
            cnt_d   = 32'd0;
            state_d = IDLE;
         end else begin
            cnt_d = cnt_q - 32'd1;
         end
      end
   end

   // State and datapath registers with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= 32'd0;
         hi_q    <= 32'd0;
         lo_q    <= 32'd0;
         thi_q   <= 32'd0;
         tlo_q   <= 32'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         thi_q   <= thi_d;
         tlo_q   <= tlo_d;
      end
   end

endmodule

// File: doc/mdu_unit.md
Name: mdu_unit

Overview:
- Multiply/divide unit in the EX stage; consumes the Start/Multop command pair produced by the decode-stage controller.
- Executes mult/multu/div/divu over a fixed multi-cycle latency.
- Owns the HI/LO registers: handles mthi/mtlo writes and supplies mfhi/mflo read data.
- Drives Busy back to the hazard unit, which stalls decode while an MDU op is in flight.

Parameters:
- MULT_CYCLES, 5, cycles Busy stays high for mult/multu (must be >=1).
- DIV_CYCLES, 10, cycles Busy stays high for div/divu (must be >=1).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- Start  input  1  EX-stage instruction is mult/multu/div/divu.
- Multop  input  4  1=mult, 2=div, 3=mthi, 4=mtlo, 5=mfhi, 6=mflo, 7=multu, 8=divu, 0/other=none.
- A  input  32  forwarded rs value.
- B  input  32  forwarded rt value.
- Req  input  1  exception/interrupt taken this cycle; cancels the EX-stage command.
- Busy  output  1  registered; high while an operation is in flight.
- HI  output  32  HI register.
- LO  output  32  LO register.
- MDUout  output  32  combinational: HI when Multop=5, LO when Multop=6, else 0.

Behaviour:
- One clock (clk); reset is synchronous and active-high (reset sampled on the clk rising edge).
- Reset: HI=0, LO=0, Busy=0, cycle counter=0, temporary result registers=0. Reset mid-operation aborts the operation; HI/LO are not updated.
- State machine: IDLE (Busy=0) and RUN (Busy=1).
- Accepted command: at an edge in IDLE, with Req=0.
- IDLE, Start=1, Multop in {1,2,7,8}, Req=0:
  - Compute the result into temporaries at this edge.
  - Load the counter with MULT_CYCLES (1,7) or DIV_CYCLES (2,8).
  - Go to RUN; Busy=1 from the next cycle.
- RUN: counter decrements each edge. At the edge where counter==1:
  - HI/LO <= temporaries.
  - Busy <= 0, return to IDLE.
  - Busy is therefore high for exactly N cycles, and new HI/LO are visible in the same cycle Busy falls.
- Arithmetic:
  - mult: signed 32x32 to 64; HI=[63:32], LO=[31:0].
  - multu: unsigned 32x32 to 64; HI=[63:32], LO=[31:0].
  - div: signed; LO=quotient truncated toward zero; HI=remainder, sign of dividend.
  - divu: unsigned; LO=quotient, HI=remainder.
- Signed overflow: div with A=0x80000000, B=0xFFFFFFFF gives LO=0x80000000, HI=0.
- Divide by zero (B=0, div or divu), default: HI=A, LO=0xFFFFFFFF, still DIV_CYCLES latency.
- mthi/mtlo: IDLE, Multop=3/4, Req=0 → HI<=A / LO<=A at the edge; Busy stays 0.
- Commands while Busy (Start or Multop 3/4): ignored. The hazard unit stalls on Start|Busy, so this is a protocol violation and must not corrupt state.
- Req=1 with a command in IDLE: command discarded, no state change.
- Req=1 while in RUN: no effect; the in-flight op was already committed and completes normally.
- Start=1 with Multop not in {1,2,7,8}: ignored.
- MDUout is purely combinational from Multop/HI/LO and is valid in the same cycle.

Optional Feature:
- Macro: MDU_DIV0_KEEP_EN.
- Defined: div/divu with B=0 leave HI and LO unchanged at completion; Busy still runs DIV_CYCLES.
- Undefined: HI=A, LO=0xFFFFFFFF as above.

Test Plan:
- Reset, then mult A=0xFFFFFFFE (-2), B=3 → Busy high exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- multu A=0xFFFFFFFF, B=2 → after 5 cycles HI=0x00000001, LO=0xFFFFFFFE; MDUout=0x00000001 with Multop=5.
- div A=-7 (0xFFFFFFF9), B=2 → Busy 10 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu same operands → LO=0x7FFFFFFC, HI=1.
- mthi A=0x12345678, then mtlo A=0x9ABCDEF0 on consecutive cycles → HI/LO updated next edge, Busy never asserted. Then Start+div while Req=1 → no Busy, HI/LO unchanged.
- divu A=0x55, B=0 → without macro HI=0x55, LO=0xFFFFFFFF; with MDU_DIV0_KEEP_EN HI/LO keep their prior values; Busy 10 cycles in both builds.
- mult started, reset asserted on cycle 3 of Busy → next cycle Busy=0, HI=LO=0. Mthi issued while Busy → ignored.
